// File: rtl/data_sync.sv
// data_sync: destination-side bus synchronizer; syncs a level enable, captures the bus once per rise, emits a pulse and a toggle ack
module data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 ACK_TOGGLE
);
  logic [NUM_STAGES-1:0] r_sync;
  logic                  r_hist;
  logic                  w_rise;
  assign w_rise = r_sync[NUM_STAGES-1] & ~r_hist;
  // plain flop chain on the enable only; the bus is never synchronized bitwise
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_sync <= '0;
    else      r_sync <= {r_sync[NUM_STAGES-2:0], BUS_ENABLE};
  // history of the chain output for rising-edge detection
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_hist <= 1'b0;
    else      r_hist <= r_sync[NUM_STAGES-1];
  // capture the now-stable bus once per synchronized rise and flip the ack
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
      ACK_TOGGLE   <= 1'b0;
    end else begin
      ENABLE_PULSE <= w_rise;
      if (w_rise) begin
        SYNC_BUS   <= UNSYNC_BUS;
        ACK_TOGGLE <= ~ACK_TOGGLE;
      end
    end
endmodule

// File: doc/data_sync.md
Name: data_sync

Overview:
- Destination-side bus synchronizer for the multi-clock UART system.
- Receives a multi-bit bus plus a level enable launched from a foreign clock domain. Synchronizes only the enable through a NUM_STAGES flop chain, then captures the stable bus once.
- Emits a single-cycle ENABLE_PULSE with the captured data. Returns a toggle acknowledge so the source side can re-synchronize and retire the transfer.
- Sits at every crossing where a configuration word or a parallel data byte moves between the REF_CLK and UART_CLK domains.

Parameters:
- NUM_STAGES, 2, depth of the enable synchronizer chain (legal range 2..4).
- BUS_WIDTH, 8, width of the data bus being transferred.

Ports:
- CLK  input  1  destination-domain clock, all state on rising edge.
- RST  input  1  asynchronous active-low reset. Asserts immediately; deassertion is assumed already synchronized upstream.
- UNSYNC_BUS  input  BUS_WIDTH  data from the source domain. Stable while BUS_ENABLE is high.
- BUS_ENABLE  input  1  source-domain level. High means UNSYNC_BUS is valid.
- SYNC_BUS  output  BUS_WIDTH  registered captured data. Holds its value between transfers.
- ENABLE_PULSE  output  1  registered, high for exactly one CLK cycle when SYNC_BUS is updated.
- ACK_TOGGLE  output  1  registered, inverts once per accepted transfer, for source-side synchronization.

Behaviour:
- Reset (RST low, asynchronous): sync chain cleared to all 0, pulse-gen history flop cleared to 0, SYNC_BUS = 0, ENABLE_PULSE = 0, ACK_TOGGLE = 0. Held for as long as RST is low.
- Sync chain: stage0 <= BUS_ENABLE; stage[i] <= stage[i-1]. The output is stage[NUM_STAGES-1]. No logic is allowed between stages.
- Pulse generation:
  - A history flop samples the chain output each edge.
  - The rise condition is chain_out & ~history. It is combinational and used only as a load enable.
- Capture: on an edge where the rise condition is true:
  - SYNC_BUS <= UNSYNC_BUS;
  - ENABLE_PULSE <= 1;
  - ACK_TOGGLE <= ~ACK_TOGGLE.
  On every other edge ENABLE_PULSE <= 0, and SYNC_BUS and ACK_TOGGLE hold.
- Latency: BUS_ENABLE is first sampled high at edge 1. The chain output goes high after edge NUM_STAGES. SYNC_BUS and ENABLE_PULSE update at edge NUM_STAGES+1. ENABLE_PULSE clears at edge NUM_STAGES+2.
- One pulse per rising edge of the enable. BUS_ENABLE held high indefinitely gives exactly one pulse. A new transfer requires BUS_ENABLE to be low for at least one sampled edge that propagates through the chain.
- Source contract, not checked by this block:
  - BUS_ENABLE high for at least NUM_STAGES+2 CLK cycles.
  - UNSYNC_BUS stable from the BUS_ENABLE rise until the ACK_TOGGLE change is seen.
  A glitch shorter than one CLK period may be missed. That is acceptable, and no X is allowed to reach the outputs.
- BUS_ENABLE falling: no pulse, no data change, ACK_TOGGLE holds.
- Back-to-back transfers: BUS_ENABLE pattern high, then low for 1 sampled cycle, then high produces two pulses separated by at least 2 cycles. SYNC_BUS carries the second word after the second pulse.
- Reset mid-operation:
  - All state clears immediately and any pending pulse is lost.
  - If BUS_ENABLE is still high when RST releases, the history is 0, so a fresh pulse fires at edge NUM_STAGES+1 after release and captures the current bus.
- SYNC_BUS never changes except in the cycle ENABLE_PULSE is asserted.

Test Plan:
- Reset values: RST low with BUS_ENABLE=1 and UNSYNC_BUS=8'hFF -> SYNC_BUS=0, ENABLE_PULSE=0, ACK_TOGGLE=0 throughout the reset.
- Single transfer (NUM_STAGES=2): UNSYNC_BUS=8'hA5, BUS_ENABLE rises before edge 1 and is held 10 cycles -> SYNC_BUS=8'hA5 and ENABLE_PULSE=1 after edge 3 only, ENABLE_PULSE=0 after edge 4, ACK_TOGGLE 0->1 once, no further pulses.
- Back-to-back: 8'h3C transfer, BUS_ENABLE low 1 cycle, then 8'hC3 -> exactly two pulses, SYNC_BUS ends at 8'hC3, ACK_TOGGLE returns to 0.
- Bus change without enable: UNSYNC_BUS toggles 8'h00/8'hFF every cycle with BUS_ENABLE=0 for 20 cycles -> SYNC_BUS, ENABLE_PULSE and ACK_TOGGLE unchanged.
- Reset mid-transfer: BUS_ENABLE high with 8'h5A, RST pulsed low after edge 1 and released, BUS_ENABLE held -> no pulse during reset, one pulse at edge 3 after release, SYNC_BUS=8'h5A.
- Parameter sweep NUM_STAGES=3,4 with BUS_WIDTH=16, word 16'hBEEF -> pulse at edge NUM_STAGES+1, exactly one cycle wide.
